fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset; bits [1:0] are forced to 0 internally.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port imem_addr, output, 32, byte address to instruction memory (word index = imem_addr[31:2]).
REQ-005 SHALL have port imem_instr, input, 32, combinational read data from instruction memory for imem_addr.
REQ-006 SHALL have port redirect_valid, input, 1, branch/jump/trap redirect request.
REQ-007 SHALL have port redirect_pc, input, 32, redirect target byte address.
REQ-008 SHALL have port out_valid, output, 1, head fetch-queue entry available to decode.
REQ-009 SHALL have port out_ready, input, 1, decode accepts head entry.
REQ-010 SHALL have port out_pc, output, 32, PC of head entry.
REQ-011 SHALL have port out_instr, output, 32, instruction word of head entry.
REQ-012 SHALL have port fetch_fault, output, 1, misaligned-redirect fault flag.
REQ-013 SHALL have port fault_pc, output, 32, offending redirect target.

Function
REQ-014 SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally from it.
REQ-015 SHALL contain a 2-entry FIFO of {pc, instr} with count 0..2; out_valid = (count != 0); out_pc/out_instr = head entry from registered storage (no bypass).
REQ-016 SHALL define pop = out_valid & out_ready; out_pc/out_instr SHALL hold stable while out_valid & !out_ready.
REQ-017 SHALL define push = (state == RUN) & !redirect_valid & (count < 2 | pop); on push, {PC, imem_instr} is written at the tail and PC <= PC + 4.
REQ-018 SHALL support simultaneous push and pop when count == 2 (count stays 2) and when count == 1 (count stays 1, order preserved).
REQ-019 SHALL make a word presented at imem_addr in cycle N visible on out_* in cycle N+1 when the queue was empty in cycle N (latency 1).
REQ-020 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-021 SHALL have states RUN and FAULT; FAULT SHALL suppress push.
REQ-022 SHALL give redirect_valid highest priority: queue flushed (count <= 0) that cycle regardless of pop or push; a pop in that cycle is still a completed handshake; the queue is empty the next cycle.
REQ-023 SHALL, on redirect with redirect_pc[1:0] == 0, load PC <= redirect_pc and go to RUN, clearing fetch_fault.
REQ-024 SHALL, on redirect with redirect_pc[1:0] != 0, leave PC unchanged, go to FAULT, set fetch_fault <= 1 and fault_pc <= redirect_pc.
REQ-025 SHALL keep fetch_fault and fault_pc stable in FAULT until an aligned redirect or reset; a further misaligned redirect in FAULT SHALL update fault_pc.
REQ-026 SHALL give the first fetch after a redirect to target T out_pc = T in the cycle after the redirect cycle + 1 (redirect cycle, fetch cycle, visible).

Reset
REQ-027 SHALL, while rst is high at a clock edge, set PC = {RESET_PC[31:2], 2'b00}, count = 0, state = RUN, fetch_fault = 0, fault_pc = 0; out_valid is 0 the following cycle.
REQ-028 SHALL give rst priority over redirect_valid and push; reset mid-operation discards all queued entries.
REQ-029 SHALL make no push in a cycle where rst is high.

Verification
REQ-030 SHALL cover reset then out_ready = 1, memory word i = 32'h1000_0000 + i -> out_valid from 2nd cycle, out_pc 0,4,8..., out_instr 32'h1000_0000, 32'h1000_0001... one per cycle.
REQ-031 SHALL cover out_ready = 0 for 5 cycles after reset -> count saturates at 2, out_pc holds 0, imem_addr holds 8; on release, entries pc 0,4,8 delivered in order, no loss or duplicate.
REQ-032 SHALL cover redirect_valid with redirect_pc = 32'h0000_0100 while count = 2 -> next cycle out_valid = 0, imem_addr = 32'h100; following cycle out_pc = 32'h100.
REQ-033 SHALL cover redirect_pc = 32'h0000_0102 -> fetch_fault = 1, fault_pc = 32'h102, out_valid = 0 and imem_addr constant thereafter; later redirect_pc = 32'h200 -> fetch_fault = 0, fetch resumes at 32'h200.
REQ-034 SHALL cover RESET_PC = 32'hFFFF_FFF8, no stall -> out_pc sequence 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000.
REQ-035 SHALL cover rst asserted for one cycle with count = 2 and redirect_valid = 1 -> queue empty, PC = RESET_PC, fetch_fault = 0, redirect ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC generator feeding a 2-entry {pc, instr} queue toward decode,
// with redirect handling and a sticky misaligned-redirect fault state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  logic [0:0]  state_r;
  logic [31:0] pc_r;
  logic [1:0]  count_r;
  logic        head_r;
  logic [31:0] q_pc_r    [2];
  logic [31:0] q_instr_r [2];
  logic        fault_r;
  logic [31:0] fault_pc_r;

  logic        pop_s;
  logic        push_s;
  logic        tail_s;
  logic        redir_ok_s;
  logic [1:0]  count_nxt_s;

  assign imem_addr   = pc_r;
  assign out_valid   = (count_r != 2'd0);
  assign out_pc      = q_pc_r[head_r];
  assign out_instr   = q_instr_r[head_r];
  assign fetch_fault = fault_r;
  assign fault_pc    = fault_pc_r;

  assign pop_s      = out_valid & out_ready;
  assign push_s     = (state_r == RUN) & ~redirect_valid & ((count_r < 2'd2) | pop_s);
  // With two slots the tail sits one past the head only when exactly one entry is held.
  assign tail_s     = head_r ^ count_r[0];
  assign redir_ok_s = (redirect_pc[1:0] == 2'b00);

  // Queue occupancy next-state from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // PC, run/fault state and fault reporting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= {RESET_PC[31:2], 2'b00};
      state_r    <= RUN;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      if (redir_ok_s) begin
        pc_r    <= redirect_pc;
        state_r <= RUN;
        fault_r <= 1'b0;
      end else begin
        state_r    <= FAULT;
        fault_r    <= 1'b1;
        fault_pc_r <= redirect_pc;
      end
    end else if (push_s) begin
      pc_r <= pc_r + 32'd4;
    end
  end

  // Queue pointers; a redirect flushes regardless of the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 2'd0;
      head_r  <= 1'b0;
    end else if (redirect_valid) begin
      count_r <= 2'd0;
      head_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (pop_s) begin
        head_r <= ~head_r;
      end
    end
  end

  // Queue storage written at the tail on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_pc_r[0]    <= 32'h0000_0000;
      q_pc_r[1]    <= 32'h0000_0000;
      q_instr_r[0] <= 32'h0000_0000;
      q_instr_r[1] <= 32'h0000_0000;
    end else if (push_s) begin
      q_pc_r[tail_s]    <= pc_r;
      q_instr_r[tail_s] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected {pc, instr} entries
// compared as decode accepts them, plus directed redirect/fault/reset scenarios.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_instr;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;
  logic        w_fetch_fault;
  logic [31:0] w_fault_pc;

  ent_t sb[$];
  ent_t wsb[$];
  ent_t e;
  int   total;
  int   bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .out_instr(w_out_instr), .fetch_fault(w_fetch_fault), .fault_pc(w_fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL reset_pc: got %h want 00000000", imem_addr); end
    total++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin bad++; $display("FAIL reset_fault: got %0b/%h want 0/00000000", fetch_fault, fault_pc); end
    total++; if (w_imem_addr !== 32'hFFFF_FFF8 || w_fetch_fault !== 1'b0 || w_fault_pc !== 32'h0) begin bad++; $display("FAIL reset_wrap_pc: got %h want fffffff8", w_imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first: got valid %0b want 0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{pc: 32'(i * 4), instr: 32'h1000_0000 + 32'(i)});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL stream_valid: cycle %0d got %0b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          bad++; $display("FAIL stream_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h8) begin
          bad++; $display("FAIL stall_hold: got v=%0b pc=%h addr=%h want 1/00000000/00000008", out_valid, out_pc, imem_addr);
        end
      end
    end
    for (int i = 0; i < 3; i++) sb.push_back('{pc: 32'(i * 4), instr: 32'h1000_0000 + 32'(i)});
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
        bad++; $display("FAIL stall_drain: got v=%0b %h/%h want %h/%h", out_valid, out_pc, out_instr, e.pc, e.instr);
      end
      tick();
    end
    total++; if (out_pc !== 32'h0000_000C) begin bad++; $display("FAIL stall_next: got %h want 0000000c", out_pc); end
    sb.delete();
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    sb.push_back('{pc: 32'h0000_0100, instr: 32'h1000_0040});
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_flush: got v=%0b addr=%h want 0/00000100", out_valid, imem_addr); end
    tick();
    e = sb.pop_front();
    total++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("FAIL redir_first: got v=%0b %h/%h want %h/%h", out_valid, out_pc, out_instr, e.pc, e.instr); end
  endtask

  task automatic test_fault();
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    total++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h102 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL fault_enter: got f=%0b fpc=%h v=%0b addr=%h want 1/00000102/0/00000008", fetch_fault, fault_pc, out_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (fetch_fault !== 1'b1 || fault_pc !== 32'h102 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin
        bad++; $display("FAIL fault_hold: got f=%0b fpc=%h v=%0b addr=%h", fetch_fault, fault_pc, out_valid, imem_addr);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    total++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h203) begin bad++; $display("FAIL fault_update: got %0b/%h want 1/00000203", fetch_fault, fault_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    sb.push_back('{pc: 32'h0000_0200, instr: 32'h1000_0080});
    tick();
    redirect_valid = 1'b0;
    total++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h200 || out_valid !== 1'b0) begin bad++; $display("FAIL fault_clear: got f=%0b addr=%h v=%0b want 0/00000200/0", fetch_fault, imem_addr, out_valid); end
    tick();
    e = sb.pop_front();
    total++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("FAIL fault_resume: got v=%0b %h/%h want %h/%h", out_valid, out_pc, out_instr, e.pc, e.instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    total++; if (w_out_valid !== 1'b0 || w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_start: got v=%0b addr=%h want 0/fffffff8", w_out_valid, w_imem_addr); end
    wsb.push_back('{pc: 32'hFFFF_FFF8, instr: 32'h4FFF_FFFE});
    wsb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h4FFF_FFFF});
    wsb.push_back('{pc: 32'h0000_0000, instr: 32'h1000_0000});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = wsb.pop_front();
      total++;
      if (w_out_valid !== 1'b1 || w_out_pc !== e.pc || w_out_instr !== e.instr) begin
        bad++; $display("FAIL wrap_seq: got v=%0b %h/%h want %h/%h", w_out_valid, w_out_pc, w_out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL mid_fill: got v=%0b addr=%h want 1/00000008", out_valid, imem_addr); end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin
      bad++; $display("FAIL mid_reset: got v=%0b addr=%h f=%0b fpc=%h want 0/00000000/0/00000000", out_valid, imem_addr, fetch_fault, fault_pc);
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin bad++; $display("FAIL mid_restart: got v=%0b %h/%h want 1/00000000/10000000", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    out_ready = 1'b0;
    w_out_ready = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0000_0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
